// File: rtl/soc_system_sysid_checker_if.sv
// rtl/soc_system_sysid_checker_if.sv - Avalon-MM read port bundle between the checker and the system-ID slave
interface soc_system_sysid_checker_if;
  logic        avm_address;
  logic        avm_read;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;

  modport master (
    output avm_address,
    output avm_read,
    input  avm_waitrequest,
    input  avm_readdata
  );

  modport slave (
    input  avm_address,
    input  avm_read,
    output avm_waitrequest,
    output avm_readdata
  );
endinterface

// File: rtl/soc_system_sysid_checker.sv
// rtl/soc_system_sysid_checker.sv - reads system ID and build timestamp, compares them against expected values
module soc_system_sysid_checker #(
  parameter logic [31:0] EXPECTED_ID    = 32'hACD51302,
  parameter logic [31:0] EXPECTED_TS    = 32'h557474E0,
  parameter int          READ_LATENCY   = 0,
  parameter int          TIMEOUT_CYCLES = 255
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              start,
  soc_system_sysid_checker_if.master        avm,
  output logic                              busy,
  output logic                              done,
  output logic [31:0]                       id_value,
  output logic [31:0]                       ts_value,
  output logic                              id_ok,
  output logic                              ts_ok,
  output logic                              timeout
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_LAT  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [15:0] STALL_LIMIT = 16'(TIMEOUT_CYCLES);
  localparam logic [1:0]  LAT_CYCLES  = 2'(READ_LATENCY);

  state_t      r_state;
  state_t      w_next_state;
  logic        r_word;
  logic [15:0] r_stall_cnt;
  logic [15:0] w_stall_next;
  logic [1:0]  r_lat_cnt;
  logic        r_avm_read;
  logic        r_busy;
  logic        r_done;
  logic        r_id_ok;
  logic        r_ts_ok;
  logic        r_timeout;
  logic [31:0] r_id_value;
  logic [31:0] r_ts_value;
  logic        w_start_acc;
  logic        w_accept;
  logic        w_capture;
  logic        w_timeout_hit;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Once the stall counter hits the limit, avm_read is already low, so that REQ cycle only aborts.
  always_comb begin
    w_next_state  = r_state;
    w_start_acc   = 1'b0;
    w_accept      = 1'b0;
    w_capture     = 1'b0;
    w_timeout_hit = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_start_acc  = 1'b1;
          w_next_state = S_REQ;
        end
      end
      S_REQ: begin
        if (r_stall_cnt == STALL_LIMIT) begin
          w_timeout_hit = 1'b1;
          w_next_state  = S_DONE;
        end else if (!avm.avm_waitrequest) begin
          w_accept = 1'b1;
          if (LAT_CYCLES == 2'd0) begin
            w_capture    = 1'b1;
            w_next_state = r_word ? S_DONE : S_REQ;
          end else begin
            w_next_state = S_LAT;
          end
        end
      end
      S_LAT: begin
        if (r_lat_cnt == 2'd1) begin
          w_capture    = 1'b1;
          w_next_state = r_word ? S_DONE : S_REQ;
        end
      end
      S_DONE: begin
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  always_comb begin
    w_stall_next = r_stall_cnt;
    if (w_start_acc || w_accept) begin
      w_stall_next = 16'd0;
    end else if (r_state == S_REQ && !w_timeout_hit) begin
      w_stall_next = r_stall_cnt + 16'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_word      <= 1'b0;
      r_stall_cnt <= 16'd0;
      r_lat_cnt   <= 2'd0;
      r_avm_read  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_id_ok     <= 1'b0;
      r_ts_ok     <= 1'b0;
      r_timeout   <= 1'b0;
      r_id_value  <= 32'd0;
      r_ts_value  <= 32'd0;
    end else begin
      r_stall_cnt <= w_stall_next;
      r_busy      <= (w_next_state != S_IDLE);
      r_done      <= (w_next_state == S_DONE);
      r_avm_read  <= (w_next_state == S_REQ) && (w_stall_next != STALL_LIMIT);

      if (w_accept) begin
        r_lat_cnt <= LAT_CYCLES;
      end else if (r_state == S_LAT) begin
        r_lat_cnt <= r_lat_cnt - 2'd1;
      end

      if (w_start_acc) begin
        r_word     <= 1'b0;
        r_id_ok    <= 1'b0;
        r_ts_ok    <= 1'b0;
        r_timeout  <= 1'b0;
        r_id_value <= 32'd0;
        r_ts_value <= 32'd0;
      end

      // Flags are only evaluated once both words are in, so a timeout leaves them at 0.
      if (w_capture) begin
        if (!r_word) begin
          r_id_value <= avm.avm_readdata;
          r_word     <= 1'b1;
        end else begin
          r_ts_value <= avm.avm_readdata;
          r_id_ok    <= (r_id_value == EXPECTED_ID);
          r_ts_ok    <= (avm.avm_readdata == EXPECTED_TS);
        end
      end

      if (w_timeout_hit) begin
        r_timeout <= 1'b1;
        r_id_ok   <= 1'b0;
        r_ts_ok   <= 1'b0;
      end
    end
  end

  assign avm.avm_read    = r_avm_read;
  assign avm.avm_address = r_word;
  assign busy            = r_busy;
  assign done            = r_done;
  assign id_value        = r_id_value;
  assign ts_value        = r_ts_value;
  assign id_ok           = r_id_ok;
  assign ts_ok           = r_ts_ok;
  assign timeout         = r_timeout;

endmodule

// File: tb/tb_soc_system_sysid_checker.sv
// tb/tb_soc_system_sysid_checker.sv - self-checking bench for soc_system_sysid_checker
module tb_soc_system_sysid_checker;
  localparam logic [31:0] EXP_ID = 32'hACD51302;
  localparam logic [31:0] EXP_TS = 32'h557474E0;
  localparam int NI = 3;

  function automatic int lat_of(input int g);
    return (g == 1) ? 2 : 0;
  endfunction

  function automatic int to_of(input int g);
    return (g == 2) ? 8 : 255;
  endfunction

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [NI-1:0]        start_v = '0;
  logic [NI-1:0]        busy_v, done_v, idok_v, tsok_v, to_v, rd_v, addr_v;
  logic [NI-1:0][31:0]  idv_v, tsv_v;

  logic [31:0] mem [NI][2];
  int          stall_cfg [NI][2];

  int total = 0;
  int bad   = 0;

  // Instance 0: latency 0, timeout 255. Instance 1: latency 2. Instance 2: timeout 8.
  for (genvar g = 0; g < NI; g++) begin : g_inst
    localparam int L = lat_of(g);
    localparam int T = to_of(g);

    soc_system_sysid_checker_if bus();

    soc_system_sysid_checker #(
      .EXPECTED_ID    (EXP_ID),
      .EXPECTED_TS    (EXP_TS),
      .READ_LATENCY   (L),
      .TIMEOUT_CYCLES (T)
    ) dut (
      .clock    (clk),
      .reset    (rst),
      .start    (start_v[g]),
      .avm      (bus.master),
      .busy     (busy_v[g]),
      .done     (done_v[g]),
      .id_value (idv_v[g]),
      .ts_value (tsv_v[g]),
      .id_ok    (idok_v[g]),
      .ts_ok    (tsok_v[g]),
      .timeout  (to_v[g])
    );

    assign rd_v[g]   = bus.avm_read;
    assign addr_v[g] = bus.avm_address;

    int   stall_left = 0;
    bit   in_req     = 0;
    int   due        = -1;
    logic due_addr   = 1'b0;

    // Slave: stalls each new request stall_cfg cycles, then returns data exactly L cycles after acceptance.
    always @(negedge clk) begin
      logic        wait_now;
      logic [31:0] garbage;
      garbage  = $urandom;
      wait_now = 1'b0;
      if (bus.avm_read) begin
        if (!in_req) begin
          in_req     = 1;
          stall_left = stall_cfg[g][bus.avm_address];
        end
        if (stall_left > 0) begin
          wait_now   = 1'b1;
          stall_left = stall_left - 1;
        end else begin
          in_req   = 0;
          due      = cyc + L;
          due_addr = bus.avm_address;
        end
      end else begin
        in_req = 0;
      end
      bus.avm_waitrequest = wait_now | (!bus.avm_read & ($urandom_range(0, 1) == 1));
      bus.avm_readdata    = (due == cyc) ? mem[g][due_addr] : garbage;
    end
  end

  bit          m_rd[$];
  bit          m_addr[$];
  logic [31:0] m_id, m_ts;
  logic        m_idok, m_tsok, m_to;
  int          m_lat;

  // Expected bus trace and results from stall counts, latency and timeout limit.
  function automatic void build_model(input int g);
    int l = lat_of(g);
    int t = to_of(g);
    m_rd.delete();
    m_addr.delete();
    m_to = 1'b0;
    m_id = 32'd0;
    m_ts = 32'd0;
    for (int w = 0; w < 2; w++) begin
      if (!m_to) begin
        if (stall_cfg[g][w] >= t) begin
          for (int i = 0; i < t; i++) begin m_rd.push_back(1'b1); m_addr.push_back(w[0]); end
          m_rd.push_back(1'b0); m_addr.push_back(w[0]);
          m_to = 1'b1;
        end else begin
          for (int i = 0; i <= stall_cfg[g][w]; i++) begin m_rd.push_back(1'b1); m_addr.push_back(w[0]); end
          for (int i = 0; i < l; i++) begin m_rd.push_back(1'b0); m_addr.push_back(w[0]); end
          if (w == 0) m_id = mem[g][0];
          else        m_ts = mem[g][1];
        end
      end
    end
    m_lat  = m_rd.size() + 1;
    m_idok = !m_to && (m_id == EXP_ID);
    m_tsok = !m_to && (m_ts == EXP_TS);
  endfunction

  task automatic run_one(input int g, input string tag);
    int c;
    bit seen;
    int trace_bad;
    build_model(g);
    @(negedge clk); start_v[g] = 1'b1;
    @(negedge clk); start_v[g] = 1'b0;
    c = 1; seen = 0; trace_bad = 0;
    while (c <= 400) begin
      if (c <= m_rd.size()) begin
        if (rd_v[g] !== m_rd[c-1] || (m_rd[c-1] && addr_v[g] !== m_addr[c-1])) trace_bad++;
      end else if (rd_v[g] !== 1'b0) begin
        trace_bad++;
      end
      if (busy_v[g] !== 1'b1) trace_bad++;
      if (done_v[g] === 1'b1) begin
        seen = 1;
        break;
      end
      @(negedge clk);
      c++;
    end
    total++;
    if (!seen || c != m_lat) begin
      bad++;
      $display("FAIL %s latency: got %0d want %0d", tag, seen ? c : -1, m_lat);
    end
    total++;
    if (trace_bad != 0) begin
      bad++;
      $display("FAIL %s bus_trace: got %0d bad cycles want 0", tag, trace_bad);
    end
    total++;
    if ({idv_v[g], tsv_v[g], idok_v[g], tsok_v[g], to_v[g]} !== {m_id, m_ts, m_idok, m_tsok, m_to}) begin
      bad++;
      $display("FAIL %s results: got id=%h ts=%h idok=%b tsok=%b to=%b want id=%h ts=%h idok=%b tsok=%b to=%b",
               tag, idv_v[g], tsv_v[g], idok_v[g], tsok_v[g], to_v[g], m_id, m_ts, m_idok, m_tsok, m_to);
    end
    @(negedge clk);
    total++;
    if ({busy_v[g], done_v[g], idv_v[g], tsv_v[g], idok_v[g], tsok_v[g], to_v[g]} !==
        {1'b0, 1'b0, m_id, m_ts, m_idok, m_tsok, m_to}) begin
      bad++;
      $display("FAIL %s hold_after_done: got busy=%b done=%b id=%h ts=%h want busy=0 done=0 id=%h ts=%h",
               tag, busy_v[g], done_v[g], idv_v[g], tsv_v[g], m_id, m_ts);
    end
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if ({busy_v, done_v, idok_v, tsok_v, to_v, rd_v, addr_v, idv_v, tsv_v} !== '0) begin
      bad++;
      $display("FAIL reset_state: got busy=%b done=%b rd=%b id0=%h want all zero", busy_v, done_v, rd_v, idv_v[0]);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_match();
    mem[0][0] = EXP_ID; mem[0][1] = EXP_TS;
    stall_cfg[0][0] = 0; stall_cfg[0][1] = 0;
    run_one(0, "match");
    total++;
    if ({idok_v[0], tsok_v[0], idv_v[0], tsv_v[0]} !== {1'b1, 1'b1, 32'hACD51302, 32'h557474E0}) begin
      bad++;
      $display("FAIL match_values: got idok=%b tsok=%b id=%h ts=%h want 1 1 acd51302 557474e0",
               idok_v[0], tsok_v[0], idv_v[0], tsv_v[0]);
    end
  endtask

  task automatic test_ts_mismatch();
    mem[0][0] = EXP_ID; mem[0][1] = 32'h557474E1;
    run_one(0, "ts_mismatch");
  endtask

  task automatic test_latency_stall();
    mem[1][0] = EXP_ID; mem[1][1] = EXP_TS;
    stall_cfg[1][0] = 3; stall_cfg[1][1] = 3;
    run_one(1, "lat2_stall3");
  endtask

  task automatic test_timeout();
    mem[2][0] = EXP_ID; mem[2][1] = EXP_TS;
    stall_cfg[2][0] = 0; stall_cfg[2][1] = 1000;
    run_one(2, "timeout_word1");
  endtask

  task automatic test_back_to_back();
    mem[0][0] = EXP_ID; mem[0][1] = EXP_TS;
    stall_cfg[0][0] = 1; stall_cfg[0][1] = 2;
    run_one(0, "b2b_first");
    run_one(0, "b2b_second");
  endtask

  task automatic test_start_while_busy();
    int dones;
    mem[0][0] = EXP_ID; mem[0][1] = EXP_TS;
    stall_cfg[0][0] = 1; stall_cfg[0][1] = 1;
    dones = 0;
    @(negedge clk); start_v[0] = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (done_v[0] === 1'b1) begin
        dones++;
        start_v[0] = 1'b0;
      end
    end
    start_v[0] = 1'b0;
    total++;
    if (dones != 1) begin
      bad++;
      $display("FAIL start_while_busy: got %0d done pulses want 1", dones);
    end
  endtask

  task automatic test_reset_mid_run();
    int dones;
    mem[2][0] = EXP_ID; mem[2][1] = EXP_TS;
    stall_cfg[2][0] = 1000; stall_cfg[2][1] = 0;
    @(negedge clk); start_v[2] = 1'b1;
    @(negedge clk); start_v[2] = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    total++;
    if ({rd_v[2], busy_v[2]} !== 2'b00) begin
      bad++;
      $display("FAIL reset_in_req: got rd=%b busy=%b want rd=0 busy=0", rd_v[2], busy_v[2]);
    end
    @(negedge clk); rst = 1'b0;

    mem[1][0] = EXP_ID; mem[1][1] = EXP_TS;
    stall_cfg[1][0] = 0; stall_cfg[1][1] = 0;
    @(negedge clk); start_v[1] = 1'b1;
    @(negedge clk); start_v[1] = 1'b0;
    @(negedge clk);
    total++;
    if ({rd_v[1], busy_v[1]} !== 2'b01) begin
      bad++;
      $display("FAIL lat_precondition: got rd=%b busy=%b want rd=0 busy=1", rd_v[1], busy_v[1]);
    end
    #2 rst = 1'b1;
    #1;
    total++;
    if ({busy_v[1], done_v[1], rd_v[1], addr_v[1], idv_v[1], tsv_v[1], idok_v[1], tsok_v[1], to_v[1]} !== '0) begin
      bad++;
      $display("FAIL reset_in_lat: got busy=%b done=%b rd=%b addr=%b id=%h want all zero",
               busy_v[1], done_v[1], rd_v[1], addr_v[1], idv_v[1]);
    end
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (i == 1) rst = 1'b0;
      if (done_v[1] === 1'b1) dones++;
    end
    total++;
    if (dones != 0) begin
      bad++;
      $display("FAIL no_done_after_reset: got %0d done pulses want 0", dones);
    end
    run_one(1, "fresh_after_reset");
  endtask

  task automatic test_random();
    int g;
    for (int n = 0; n < 24; n++) begin
      g = $urandom_range(0, NI - 1);
      mem[g][0] = ($urandom_range(0, 1) == 1) ? EXP_ID : 32'($urandom);
      mem[g][1] = ($urandom_range(0, 1) == 1) ? EXP_TS : 32'($urandom);
      if (g == 2) begin
        stall_cfg[g][0] = $urandom_range(0, 10);
        stall_cfg[g][1] = $urandom_range(0, 10);
      end else begin
        stall_cfg[g][0] = $urandom_range(0, 4);
        stall_cfg[g][1] = $urandom_range(0, 4);
      end
      run_one(g, $sformatf("random%0d_inst%0d", n, g));
    end
  endtask

  initial begin
    for (int g = 0; g < NI; g++) begin
      mem[g][0] = 32'd0; mem[g][1] = 32'd0;
      stall_cfg[g][0] = 0; stall_cfg[g][1] = 0;
    end
    test_reset();
    test_match();
    test_ts_mismatch();
    test_latency_stall();
    test_timeout();
    test_back_to_back();
    test_start_while_busy();
    test_reset_mid_run();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/soc_system_sysid_checker.md
# soc_system_sysid_checker

Avalon-MM read master that sits directly downstream of the system-ID slave in `soc_system`. On a start pulse it reads word 0 (system ID) and word 1 (build timestamp) over the slave's 1-bit address space. It compares both words against parameterised expected values and reports match/mismatch/timeout flags plus the captured words. It gates fabric bring-up logic so that it only runs against the expected FPGA image.

## Interface
- `EXPECTED_ID`, 32'hACD51302, expected word at address 0
- `EXPECTED_TS`, 32'h557474E0, expected word at address 1
- `READ_LATENCY`, 0, fixed slave read latency in cycles, legal 0..3
- `TIMEOUT_CYCLES`, 255, max consecutive stalled cycles per read, legal 1..65535

- `clock`  in  1  system clock
- `reset`  in  1  asynchronous, active-high reset
- `start`  in  1  single-cycle request to run a check; sampled only in IDLE
- `avm_address`  out  1  word select: 0 = ID, 1 = timestamp
- `avm_read`  out  1  read request
- `avm_waitrequest`  in  1  slave stall
- `avm_readdata`  in  32  slave read data
- `busy`  out  1  high from start acceptance until the cycle after `done`
- `done`  out  1  one-cycle pulse when results are valid
- `id_value`  out  32  captured word 0
- `ts_value`  out  32  captured word 1
- `id_ok`  out  1  `id_value == EXPECTED_ID`
- `ts_ok`  out  1  `ts_value == EXPECTED_TS`
- `timeout`  out  1  last run aborted on a stall

## Operation
- States: IDLE, REQ, LAT, DONE. Internal `word` bit drives `avm_address`.
- Reset value of every output and register is 0; state is IDLE.
- IDLE:
  - `start=1` → REQ with `word=0`, `busy=1`.
  - Also clears `id_ok`, `ts_ok`, `timeout`, `id_value`, `ts_value`.
- REQ:
  - `avm_read=1` and `avm_address=word`.
  - The read is accepted on the cycle with `avm_waitrequest=0`.
  - If `READ_LATENCY=0`, capture `avm_readdata` on the acceptance cycle. Otherwise go to LAT with the latency counter loaded.
  - After capture: if `word=0`, set `word=1` and stay in or re-enter REQ. If `word=1`, go to DONE.
- LAT:
  - `avm_read=0`. Count `READ_LATENCY` cycles.
  - Capture `avm_readdata` on the final count cycle.
  - Next-state rules are the same as capture in REQ.
- Stall counter:
  - Increments each REQ cycle with `avm_waitrequest=1`.
  - Clears on acceptance and on each new word.
  - On reaching `TIMEOUT_CYCLES`: deassert `avm_read`, set `timeout=1`, force `id_ok=ts_ok=0`, go to DONE. Words not yet read keep value 0.
- DONE:
  - `done=1` for one cycle; `id_ok`/`ts_ok` are registered compares of the captured words unless the run timed out.
  - → IDLE; `busy` drops on the IDLE entry cycle.
- `start` in any state other than IDLE is ignored; it is not queued.
- Result outputs hold their values until the next accepted `start`.
- Reset asserted mid-run: outputs go to 0 immediately and no `done` is produced. `avm_read` drops asynchronously.

## Timing
- All outputs are registered; no combinational path from inputs to outputs.
- Best case (`READ_LATENCY=0`, no stalls), with `start` sampled high at edge 0:
  - Cycle 1: `avm_read=1`, address 0.
  - Cycle 2: `avm_read=1`, address 1.
  - Cycle 3: `done=1` with valid flags.
  - `busy` is high in cycles 1–3.
- General latency from start to `done` is 3 + 2·READ_LATENCY + (total stall cycles) cycles.
- `avm_address` is stable whenever `avm_read=1`.
- `avm_read` never asserts in LAT, DONE or IDLE.
- Timeout run: `done` asserts exactly `TIMEOUT_CYCLES`+1 cycles after `avm_read` first rises for the stalled word, counted with no acceptance.

## Test plan
- Matching slave, latency 0, no stalls, `start` pulse:
  - Reads at address 0 then 1 on consecutive cycles.
  - `done` asserts 3 cycles after start.
  - `id_ok=ts_ok=1`, `id_value=ACD51302`, `ts_value=557474E0`.
- Slave returns `ts=557474E1`:
  - `id_ok=1`, `ts_ok=0`, `timeout=0`, `ts_value=557474E1`.
- `READ_LATENCY=2`, waitrequest held 3 cycles on each word:
  - `avm_read` is low during latency.
  - Data is captured 2 cycles after acceptance.
  - `done` asserts 3+4+6=13 cycles after start.
- `TIMEOUT_CYCLES=8`, waitrequest stuck high on word 1:
  - `done` asserts with `timeout=1` and `id_ok=ts_ok=0`.
  - `id_value` holds the captured ID; `ts_value=0`.
- `start` pulsed while `busy`, and `reset` asserted in LAT:
  - The extra start is ignored and exactly one `done` results.
  - Reset zeroes all outputs, with no `done`.
  - A fresh `start` after reset completes normally.
